if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the instruction, PCNow and PCNext4 values consumed by the IF/ID pipeline register.
- Owns the PC and drives a request/ready instruction-memory port that tolerates variable latency.
- Accepts a redirect (branch/jump) and a stall (hazard unit) from later stages.
- Holds a one-entry skid buffer so a response landing during a stall is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction_out value whenever inst_valid=0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  downstream hold; outputs frozen while high.
- redirect_valid  input  1  flush and redirect PC this cycle.
- redirect_pc  input  32  redirect target.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  input  1  response strobe; data valid the same cycle; ignored when imem_req=0.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  instruction_out holds a real instruction.
- instruction_out  output  32  fetched instruction.
- PCNext4_out  output  32  PCNow_out + 4.
- PCNow_out  output  32  address of instruction_out.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0; imem_addr=RESET_PC.
  - inst_valid=0; instruction_out=NOP_INSTR; PCNext4_out=0; PCNow_out=0.
  - Skid buffer empty.
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE:
  - First cycle after reset release.
  - Next state FETCH; no request issued.
- FETCH:
  - imem_req=1 and imem_addr=pc whenever stall=0 or the output is empty.
  - On imem_ready with stall=0: output registers load {1, rdata, pc+4, pc} next edge; pc<=pc+4.
  - On imem_ready with stall=1: data goes to the skid buffer; pc<=pc+4; next state HOLD.
  - Minimum latency: instruction visible one cycle after the ready cycle. Back-to-back ready gives one instruction per cycle.
- HOLD:
  - imem_req=0; outputs frozen.
  - When stall=0: skid moves to the outputs; next state FETCH.
- DRAIN:
  - Entered on redirect while a request is outstanding without ready.
  - Keeps imem_req=1 with the old imem_addr until ready.
  - Discards the response data; then state FETCH at the redirect target.
- Redirect (priority over stall):
  - Next edge: inst_valid=0, instruction_out=NOP_INSTR, PCNow_out/PCNext4_out keep their old values.
  - Skid buffer cleared; pc<=redirect_pc.
  - In FETCH with imem_ready in the same cycle: response discarded, no DRAIN, next state FETCH.
  - In DRAIN: the newest redirect_pc wins.
  - In HOLD: skid dropped; next state FETCH.
- Stall with no redirect:
  - All four outputs hold their values.
  - No new request starts. An outstanding request completes into the skid buffer.
- Arithmetic: 32-bit modulo. pc 32'hFFFF_FFFC + 4 = 0, and PCNext4_out = 0 in that case.
- Never more than one outstanding request; never two ready-acceptances per cycle.

Optional Feature:
- Macro: IF_FETCH_MISALIGN_EN.
- Defined:
  - Adds output port fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 issues no request. Next edge: fetch_fault=1, inst_valid=0, PCNow_out=redirect_pc.
  - FSM parks in IDLE until the next redirect, which clears fetch_fault.
- Undefined:
  - No fetch_fault port.
  - redirect_pc[1:0] is forced to 2'b00 before loading pc.

Test Plan:
- Reset asserted mid-FETCH with imem_req=1 -> same cycle imem_req=0, inst_valid=0, imem_addr=RESET_PC. First request at 0x0 two cycles after release.
- imem_ready every cycle, stall=0, from pc=0 -> PCNow_out 0,4,8,12 on consecutive cycles; PCNext4_out 4,8,12,16; instruction_out = matching rdata.
- stall raised in the cycle imem_ready returns 0x2008_0005 for pc=0x10 -> outputs frozen, imem_req=0 during stall. One cycle after stall drops: instruction_out=0x2008_0005, PCNow_out=0x10.
- Redirect to 0x40 while a request for 0x20 waits 3 cycles -> imem_addr stays 0x20 until ready; that data never reaches inst_valid=1. Next request is 0x40.
- Redirect to 0x80 together with stall=1 and a full output -> next edge inst_valid=0, instruction_out=NOP_INSTR, skid cleared, next imem_addr=0x80.
- Redirect to 0xFFFF_FFFC, ready returned -> PCNow_out=0xFFFF_FFFC, PCNext4_out=0, following imem_addr=0. With IF_FETCH_MISALIGN_EN, redirect to 0x42 -> fetch_fault=1, imem_req stays 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with PC, variable-latency imem port and one-entry skid buffer.
// Optional feature: define IF_FETCH_MISALIGN_EN to add fetch_fault and park on misaligned redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction_out,
    output logic [31:0] PCNext4_out,
    output logic [31:0] PCNow_out
`ifdef IF_FETCH_MISALIGN_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        pend_q, pend_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcnow_q, pcnow_d;
    logic [31:0] pcn4_q, pcn4_d;
    logic        fault_q, fault_d;
    logic        accept;
    logic        busy;
    logic        misaligned;
    logic [31:0] redir_tgt;

`ifdef IF_FETCH_MISALIGN_EN
    assign misaligned  = redirect_pc[1:0] != 2'b00;
    assign redir_tgt   = redirect_pc;
    assign fetch_fault = fault_q;
`else
    assign misaligned  = 1'b0;
    assign redir_tgt   = redirect_pc & ~32'h3;
`endif

    assign imem_addr       = pc_q;
    assign inst_valid      = valid_q;
    assign instruction_out = instr_q;
    assign PCNow_out       = pcnow_q;
    assign PCNext4_out     = pcn4_q;

    // Request generation plus next-state for PC, FSM, skid buffer and output registers.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pcnow_d     = pcnow_q;
        pcn4_d      = pcn4_q;
        fault_d     = fault_q;
        imem_req    = state_q == DRAIN ||
                      (state_q == FETCH && (!stall || !valid_q || pend_q));
        accept      = imem_req && imem_ready;
        busy        = imem_req && !imem_ready;
        pend_d      = busy;
        if (redirect_valid) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            fault_d = misaligned;
            if (misaligned) pcnow_d = redirect_pc;
            if (busy) begin
                state_d = DRAIN;
                tgt_d   = redir_tgt;
            end else begin
                state_d = misaligned ? IDLE : FETCH;
                pc_d    = redir_tgt;
            end
        end else begin
            case (state_q)
                IDLE: state_d = fault_q ? IDLE : FETCH;
                FETCH: begin
                    if (accept) begin
                        pc_d = pc_q + 32'd4;
                        if (stall) begin
                            skid_data_d = imem_rdata;
                            skid_pc_d   = pc_q;
                            state_d     = HOLD;
                        end else begin
                            valid_d = 1'b1;
                            instr_d = imem_rdata;
                            pcnow_d = pc_q;
                            pcn4_d  = pc_q + 32'd4;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        pc_d    = tgt_q;
                        state_d = fault_q ? IDLE : FETCH;
                    end
                end
                default: begin
                    if (!stall) begin
                        valid_d = 1'b1;
                        instr_d = skid_data_q;
                        pcnow_d = skid_pc_q;
                        pcn4_d  = skid_pc_q + 32'd4;
                        state_d = FETCH;
                    end
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            tgt_q       <= RESET_PC;
            pend_q      <= 1'b0;
            skid_data_q <= NOP_INSTR;
            skid_pc_q   <= 32'h0;
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            pcnow_q     <= 32'h0;
            pcn4_q      <= 32'h0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pcnow_q     <= pcnow_d;
            pcn4_q      <= pcn4_d;
            fault_q     <= fault_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] instruction_out;
    logic [31:0] PCNext4_out;
    logic [31:0] PCNow_out;
`ifdef IF_FETCH_MISALIGN_EN
    logic        fetch_fault;
`endif
    int checks = 0;
    int passes = 0;

    if_fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .instruction_out(instruction_out),
        .PCNext4_out(PCNext4_out),
        .PCNow_out(PCNow_out)
`ifdef IF_FETCH_MISALIGN_EN
        ,
        .fetch_fault(fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input logic [31:0] rd);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        imem_rdata     = rd;
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_instr", instruction_out, 32'h0);
        check("rst_pcnow", PCNow_out, 32'h0);
        check("rst_pcn4", PCNext4_out, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        reset = 1'b0;
        #1;
        check("idle_req", {31'b0, imem_req}, 32'd0);
        cyc();
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 32'h1000_0000 + i);
            check("b2b_addr", imem_addr, 32'(4 * i));
            cyc();
            check("b2b_valid", {31'b0, inst_valid}, 32'd1);
            check("b2b_pcnow", PCNow_out, 32'(4 * i));
            check("b2b_pcn4", PCNext4_out, 32'(4 * i + 4));
            check("b2b_instr", instruction_out, 32'h1000_0000 + i);
        end
        drive(0, 0, 0, 0, 0);
        check("stl_addr", imem_addr, 32'h10);
        check("stl_req", {31'b0, imem_req}, 32'd1);
        cyc();
        drive(1, 0, 0, 1, 32'h2008_0005);
        check("stl_pend_req", {31'b0, imem_req}, 32'd1);
        cyc();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("stl_hold_req", {31'b0, imem_req}, 32'd0);
            check("stl_hold_pcnow", PCNow_out, 32'hC);
            check("stl_hold_instr", instruction_out, 32'h1000_0003);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        cyc();
        check("skid_instr", instruction_out, 32'h2008_0005);
        check("skid_pcnow", PCNow_out, 32'h10);
        check("skid_pcn4", PCNext4_out, 32'h14);
        check("skid_valid", {31'b0, inst_valid}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            drive(0, 0, 0, 1, 32'h3000_0000 + j);
            cyc();
            check("run_pcnow", PCNow_out, 32'(32'h14 + 4 * j));
        end
        drive(0, 0, 0, 0, 0);
        check("drn_addr0", imem_addr, 32'h20);
        cyc();
        drive(0, 1, 32'h40, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("drn_req", {31'b0, imem_req}, 32'd1);
            check("drn_addr", imem_addr, 32'h20);
            check("drn_valid", {31'b0, inst_valid}, 32'd0);
            cyc();
        end
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        check("drn_last_addr", imem_addr, 32'h20);
        cyc();
        drive(0, 0, 0, 0, 0);
        check("drn_valid_after", {31'b0, inst_valid}, 32'd0);
        check("drn_new_addr", imem_addr, 32'h40);
        check("drn_new_req", {31'b0, imem_req}, 32'd1);
        drive(0, 0, 0, 1, 32'h4000_0040);
        cyc();
        check("tgt_instr", instruction_out, 32'h4000_0040);
        drive(1, 1, 32'h80, 0, 0);
        check("rs_req", {31'b0, imem_req}, 32'd0);
        cyc();
        check("rs_valid", {31'b0, inst_valid}, 32'd0);
        check("rs_instr", instruction_out, 32'h0);
        check("rs_pcnow", PCNow_out, 32'h40);
        check("rs_pcn4", PCNext4_out, 32'h44);
        drive(0, 0, 0, 0, 0);
        check("rs_addr", imem_addr, 32'h80);
        check("rs_req2", {31'b0, imem_req}, 32'd1);
        cyc();
        drive(1, 0, 0, 1, 32'h8000_0080);
        cyc();
        drive(1, 1, 32'hFFFF_FFFC, 0, 0);
        check("hold_rd_req", {31'b0, imem_req}, 32'd0);
        cyc();
        check("hold_rd_valid", {31'b0, inst_valid}, 32'd0);
        drive(0, 0, 0, 1, 32'hCAFE_0001);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        check("wrap_pcnow", PCNow_out, 32'hFFFF_FFFC);
        check("wrap_pcn4", PCNext4_out, 32'h0);
        check("wrap_instr", instruction_out, 32'hCAFE_0001);
        drive(0, 0, 0, 0, 0);
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_next_req", {31'b0, imem_req}, 32'd1);
`ifdef IF_FETCH_MISALIGN_EN
        drive(0, 0, 0, 1, 32'h5000_0000);
        cyc();
        drive(1, 1, 32'h42, 0, 0);
        cyc();
        check("mis_fault", {31'b0, fetch_fault}, 32'd1);
        check("mis_valid", {31'b0, inst_valid}, 32'd0);
        check("mis_pcnow", PCNow_out, 32'h42);
        drive(0, 0, 0, 0, 0);
        check("mis_req", {31'b0, imem_req}, 32'd0);
        cyc();
        check("mis_park_req", {31'b0, imem_req}, 32'd0);
        drive(0, 1, 32'h100, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        check("mis_clear", {31'b0, fetch_fault}, 32'd0);
        check("mis_resume_addr", imem_addr, 32'h100);
`endif
        drive(0, 0, 0, 0, 0);
        check("mid_req", {31'b0, imem_req}, 32'd1);
        cyc();
        reset = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_pcnow", PCNow_out, 32'h0);
        cyc();
        reset = 1'b0;
        #1;
        check("mid_idle_req", {31'b0, imem_req}, 32'd0);
        cyc();
        check("mid_first_req", {31'b0, imem_req}, 32'd1);
        check("mid_first_addr", imem_addr, 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
